// File: rtl/branch_predictor_if.sv
// Fetch/execute connection for the branch predictor: the fetch lookup, the
// execute-stage training port, the misprediction flag and the counters.
interface branch_predictor_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic [XLEN-1:0]  pc_f;
  logic             pred_taken_f;
  logic [XLEN-1:0]  pred_target_f;
  logic             upd_valid;
  logic [XLEN-1:0]  upd_pc;
  logic             upd_is_jump;
  logic             upd_taken;
  logic [XLEN-1:0]  upd_target;
  logic             upd_pred_taken;
  logic [XLEN-1:0]  upd_pred_target;
  logic             mispredict_e;
  logic [CNT_W-1:0] mispredict_cnt;
  logic [CNT_W-1:0] hit_cnt;

  modport master (
    output pc_f, upd_valid, upd_pc, upd_is_jump, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target,
    input  pred_taken_f, pred_target_f, mispredict_e, mispredict_cnt, hit_cnt
  );

  modport slave (
    input  pc_f, upd_valid, upd_pc, upd_is_jump, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target,
    output pred_taken_f, pred_target_f, mispredict_e, mispredict_cnt, hit_cnt
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters: combinational fetch lookup,
// execute-stage training, misprediction detection and saturating perf counters.
module branch_predictor #(
  parameter int XLEN     = 32,
  parameter int IDX_BITS = 4,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  branch_predictor_if.slave bp
);
  localparam int ENTRIES = 2 ** IDX_BITS;
  localparam int TAG_W   = XLEN - IDX_BITS - 2;

  // 2-bit saturating counter step toward the resolved outcome
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    if (taken) begin
      if (ctr == 2'b11) res = 2'b11;
      else              res = ctr + 2'b01;
    end else begin
      if (ctr == 2'b00) res = 2'b00;
      else              res = ctr - 2'b01;
    end
    return res;
  endfunction

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic en);
    logic [CNT_W-1:0] res;
    if (en && (cnt != {CNT_W{1'b1}})) res = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    else                              res = cnt;
    return res;
  endfunction

  logic              valid_r  [ENTRIES];
  logic [TAG_W-1:0]  tag_r    [ENTRIES];
  logic [XLEN-1:0]   target_r [ENTRIES];
  logic [1:0]        ctr_r    [ENTRIES];
  logic [CNT_W-1:0]  mispredict_cnt_r;
  logic [CNT_W-1:0]  hit_cnt_r;

  logic [IDX_BITS-1:0] f_idx_s;
  logic [TAG_W-1:0]    f_tag_s;
  logic                f_hit_s;
  logic                pred_taken_s;
  logic [XLEN-1:0]     pred_target_s;
  logic [IDX_BITS-1:0] u_idx_s;
  logic [TAG_W-1:0]    u_tag_s;
  logic                u_hit_s;
  logic                mispredict_s;
  logic                unused_s;

  // Byte-offset bits of word-aligned PCs carry no information here
  assign unused_s = ^{bp.pc_f[1:0], bp.upd_pc[1:0]};

  // Fetch lookup from registered table state (no bypass of same-cycle updates)
  always_comb begin
    f_idx_s      = bp.pc_f[IDX_BITS+1:2];
    f_tag_s      = bp.pc_f[XLEN-1:IDX_BITS+2];
    f_hit_s      = valid_r[f_idx_s] && (tag_r[f_idx_s] == f_tag_s);
    pred_taken_s = f_hit_s & ctr_r[f_idx_s][1];
    if (pred_taken_s) begin
      pred_target_s = target_r[f_idx_s];
    end else begin
      pred_target_s = {XLEN{1'b0}};
    end
  end

  // Execute-side index/tag match and misprediction detection
  always_comb begin
    u_idx_s      = bp.upd_pc[IDX_BITS+1:2];
    u_tag_s      = bp.upd_pc[XLEN-1:IDX_BITS+2];
    u_hit_s      = valid_r[u_idx_s] && (tag_r[u_idx_s] == u_tag_s);
    mispredict_s = bp.upd_valid &
                   ((bp.upd_taken != bp.upd_pred_taken) |
                    (bp.upd_taken & bp.upd_pred_taken &
                     (bp.upd_target != bp.upd_pred_target)));
  end

  // BTB training: strengthen/weaken on hit, allocate only on a taken miss
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_r[i]  <= 1'b0;
        tag_r[i]    <= {TAG_W{1'b0}};
        target_r[i] <= {XLEN{1'b0}};
        ctr_r[i]    <= 2'b01;
      end
    end else if (bp.upd_valid) begin
      if (u_hit_s) begin
        if (bp.upd_is_jump) begin
          ctr_r[u_idx_s]    <= 2'b11;
          target_r[u_idx_s] <= bp.upd_target;
        end else begin
          ctr_r[u_idx_s] <= ctr_next(ctr_r[u_idx_s], bp.upd_taken);
          if (bp.upd_taken) begin
            target_r[u_idx_s] <= bp.upd_target;
          end
        end
      end else if (bp.upd_taken) begin
        valid_r[u_idx_s]  <= 1'b1;
        tag_r[u_idx_s]    <= u_tag_s;
        target_r[u_idx_s] <= bp.upd_target;
        ctr_r[u_idx_s]    <= bp.upd_is_jump ? 2'b11 : 2'b10;
      end
    end
  end

  // Performance counters, saturating
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mispredict_cnt_r <= {CNT_W{1'b0}};
      hit_cnt_r        <= {CNT_W{1'b0}};
    end else begin
      mispredict_cnt_r <= sat_inc(mispredict_cnt_r, mispredict_s);
      hit_cnt_r        <= sat_inc(hit_cnt_r, f_hit_s);
    end
  end

  assign bp.pred_taken_f   = pred_taken_s;
  assign bp.pred_target_f  = pred_target_s;
  assign bp.mispredict_e   = mispredict_s;
  assign bp.mispredict_cnt = mispredict_cnt_r;
  assign bp.hit_cnt        = hit_cnt_r;
endmodule
